// File: rtl/pc_branch_if.sv
// Handshake/bus bundle between the ALU-side control and the PC/branch stage.
// The master drives the retire and branch inputs; the slave returns PC, link and pulses.
interface pc_branch_if;
    logic        step;
    logic        halt_req;
    logic        resume;
    logic [3:0]  br_type;
    logic [31:0] br_offset;
    logic [31:0] br_reg;
    logic [4:0]  alu_flags;
    logic        flags_we;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        link_we;
    logic        taken;
    logic        flush;
    logic [4:0]  flags_q;
    logic        halted;

    modport master (
        output step, halt_req, resume, br_type, br_offset, br_reg, alu_flags, flags_we,
        input  pc, link_addr, link_we, taken, flush, flags_q, halted
    );

    modport slave (
        input  step, halt_req, resume, br_type, br_offset, br_reg, alu_flags, flags_we,
        output pc, link_addr, link_we, taken, flush, flags_q, halted
    );
endinterface

// File: rtl/pc_branch_unit.sv
// PC update and branch resolution for KGP-RISC, with a run/halt controller gating PC advance.
//   state | meaning
//   RUN   | retiring instructions advance the PC and resolve branches
//   HALT  | PC frozen, all retire inputs ignored until resume
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_branch_if.slave    bus
);
    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    localparam logic [3:0] BR_B    = 4'd1;
    localparam logic [3:0] BR_BR   = 4'd2;
    localparam logic [3:0] BR_BLTZ = 4'd3;
    localparam logic [3:0] BR_BZ   = 4'd4;
    localparam logic [3:0] BR_BNZ  = 4'd5;
    localparam logic [3:0] BR_BL   = 4'd6;
    localparam logic [3:0] BR_BCY  = 4'd7;
    localparam logic [3:0] BR_BNCY = 4'd8;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] link_q, link_d;
    logic [4:0]  flags_q, flags_d;
    logic        link_we_d, taken_d;
    logic        link_we_q, taken_q;
    logic        cond;
    logic [31:0] target;
    logic [31:0] pc_seq;

    // Carry-class branches read the stored flags so an add in the same cycle cannot affect them.
    always_comb begin
        cond = 1'b0;
        unique case (bus.br_type)
            BR_B, BR_BR, BR_BL: cond = 1'b1;
            BR_BLTZ:            cond = bus.alu_flags[0];
            BR_BZ:              cond = bus.alu_flags[1];
            BR_BNZ:             cond = bus.alu_flags[2];
            BR_BCY:             cond = flags_q[4];
            BR_BNCY:            cond = flags_q[3];
            default:            cond = 1'b0;
        endcase
    end

    assign pc_seq = pc_q + PC_STEP;

    always_comb begin
        target = (bus.br_type == BR_BR) ? bus.br_reg : pc_q + bus.br_offset;
        target[1:0] = 2'b00;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        link_d    = link_q;
        flags_d   = flags_q;
        link_we_d = 1'b0;
        taken_d   = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (bus.step) begin
                    pc_d    = cond ? target : pc_seq;
                    taken_d = cond;
                    if (bus.br_type == BR_BL) begin
                        link_d    = pc_seq;
                        link_we_d = 1'b1;
                    end
                    if (bus.flags_we) flags_d = bus.alu_flags;
                end
                if (bus.halt_req) state_d = S_HALT;
            end
            S_HALT: begin
                if (bus.resume) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            pc_q      <= RESET_PC;
            link_q    <= 32'd0;
            flags_q   <= 5'd0;
            link_we_q <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            link_q    <= link_d;
            flags_q   <= flags_d;
            link_we_q <= link_we_d;
            taken_q   <= taken_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.link_addr = link_q;
    assign bus.link_we   = link_we_q;
    assign bus.taken     = taken_q;
    assign bus.flush     = taken_q;
    assign bus.flags_q   = flags_q;
    assign bus.halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vector table plus randomized run against a behavioural model of pc_branch_unit.
module tb_pc_branch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_branch_if bus ();

    pc_branch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_pc, m_link;
    logic [4:0]  m_flags;
    logic        m_lwe, m_tk, m_halt;

    typedef struct {
        logic        step, hreq, res;
        logic [3:0]  bt;
        logic [31:0] off, breg;
        logic [4:0]  fl;
        logic        fwe;
        logic [31:0] e_pc;
        logic        e_tk, e_lwe;
        logic [31:0] e_link;
        logic        e_halt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic h, logic r, logic [3:0] bt, logic [31:0] off,
                                logic [31:0] breg, logic [4:0] fl, logic fwe, logic [31:0] e_pc,
                                logic e_tk, logic e_lwe, logic [31:0] e_link, logic e_halt);
        vec_t v;
        v.step = s; v.hreq = h; v.res = r; v.bt = bt; v.off = off; v.breg = breg;
        v.fl = fl; v.fwe = fwe; v.e_pc = e_pc; v.e_tk = e_tk; v.e_lwe = e_lwe;
        v.e_link = e_link; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 32'h0; m_link = 32'h0; m_flags = 5'h0;
        m_lwe = 1'b0; m_tk = 1'b0; m_halt = 1'b0;
    endfunction

    // Architectural behaviour of one rising edge, from the branch rules.
    function automatic void model_edge();
        logic        c;
        logic [31:0] tgt;
        m_lwe = 1'b0;
        m_tk  = 1'b0;
        if (m_halt) begin
            if (bus.resume) m_halt = 1'b0;
            return;
        end
        if (bus.step) begin
            case (bus.br_type)
                4'd1, 4'd2, 4'd6: c = 1'b1;
                4'd3: c = bus.alu_flags[0];
                4'd4: c = bus.alu_flags[1];
                4'd5: c = bus.alu_flags[2];
                4'd7: c = m_flags[4];
                4'd8: c = m_flags[3];
                default: c = 1'b0;
            endcase
            tgt = (bus.br_type == 4'd2) ? bus.br_reg : m_pc + bus.br_offset;
            tgt = tgt & 32'hFFFF_FFFC;
            if (bus.br_type == 4'd6) begin
                m_link = m_pc + 32'd4;
                m_lwe  = 1'b1;
            end
            m_pc = c ? tgt : m_pc + 32'd4;
            m_tk = c;
            if (bus.flags_we) m_flags = bus.alu_flags;
        end
        if (bus.halt_req) m_halt = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(logic s, logic h, logic r, logic [3:0] bt, logic [31:0] off,
                         logic [31:0] breg, logic [4:0] fl, logic fwe);
        bus.step = s; bus.halt_req = h; bus.resume = r; bus.br_type = bt;
        bus.br_offset = off; bus.br_reg = breg; bus.alu_flags = fl; bus.flags_we = fwe;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".pc"},      bus.pc,        m_pc);
        chk({tag, ".link"},    bus.link_addr, m_link);
        chk({tag, ".link_we"}, {31'd0, bus.link_we}, {31'd0, m_lwe});
        chk({tag, ".taken"},   {31'd0, bus.taken},   {31'd0, m_tk});
        chk({tag, ".flush"},   {31'd0, bus.flush},   {31'd0, m_tk});
        chk({tag, ".flags"},   {27'd0, bus.flags_q}, {27'd0, m_flags});
        chk({tag, ".halted"},  {31'd0, bus.halted},  {31'd0, m_halt});
    endtask

    initial begin
        drive(0, 0, 0, 4'd0, 32'h0, 32'h0, 5'h0, 0);
        model_reset();
        //    step h r  bt    off            breg           fl        fwe  pc             tk lwe link     halt
        tbl.push_back(mk(1, 0, 0, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h4,        0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h8,        0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'hC,        0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd1, 32'hF4,       32'h0,        5'b00000, 0, 32'h100,      1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd4, 32'hFFFF_FFF0, 32'h0,       5'b00010, 0, 32'hF0,       1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd2, 32'h0,        32'h100,      5'b00000, 0, 32'h100,      1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd5, 32'hFFFF_FFF0, 32'h0,       5'b00010, 0, 32'h104,      0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 32'h0,        32'h0,        5'b10100, 1, 32'h108,      0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd2, 32'h0,        32'h200,      5'b00000, 0, 32'h200,      1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd7, 32'h8,        32'h0,        5'b00000, 0, 32'h208,      1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd7, 32'h8,        32'h0,        5'b01100, 1, 32'h210,      1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd7, 32'h8,        32'h0,        5'b00000, 0, 32'h214,      0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd8, 32'h8,        32'h0,        5'b00000, 0, 32'h21C,      1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd2, 32'h0,        32'h40,       5'b00000, 0, 32'h40,       1, 0, 32'h0,  0));
        tbl.push_back(mk(1, 0, 0, 4'd6, 32'h20,       32'h0,        5'b00000, 0, 32'h60,       1, 1, 32'h44, 0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h64,       0, 0, 32'h44, 0));
        tbl.push_back(mk(1, 0, 0, 4'd2, 32'h0,        32'h47,       5'b00000, 0, 32'h44,       1, 0, 32'h44, 0));
        tbl.push_back(mk(1, 1, 0, 4'd1, 32'h10,       32'h0,        5'b00000, 0, 32'h54,       1, 0, 32'h44, 1));
        tbl.push_back(mk(1, 0, 0, 4'd4, 32'h100,      32'h0,        5'b11111, 1, 32'h54,       0, 0, 32'h44, 1));
        tbl.push_back(mk(0, 0, 1, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h54,       0, 0, 32'h44, 0));
        tbl.push_back(mk(0, 1, 0, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h54,       0, 0, 32'h44, 1));
        tbl.push_back(mk(1, 1, 0, 4'd6, 32'h8,        32'h0,        5'b00000, 0, 32'h54,       0, 0, 32'h44, 1));
        tbl.push_back(mk(0, 0, 1, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h54,       0, 0, 32'h44, 0));
        tbl.push_back(mk(1, 0, 0, 4'd2, 32'h0,        32'hFFFF_FFFC, 5'b00000, 0, 32'hFFFF_FFFC, 1, 0, 32'h44, 0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h44, 0));
        tbl.push_back(mk(1, 0, 0, 4'd12, 32'h40,      32'h80,       5'b11111, 0, 32'h4,        0, 0, 32'h44, 0));
        tbl.push_back(mk(0, 0, 0, 4'd1, 32'h40,       32'h0,        5'b11111, 1, 32'h4,        0, 0, 32'h44, 0));

        #12;
        chk("reset.pc",      bus.pc, 32'h0);
        chk("reset.pulses",  {29'd0, bus.link_we, bus.taken, bus.flush}, 32'h0);
        chk("reset.halted",  {31'd0, bus.halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].step, tbl[i].hreq, tbl[i].res, tbl[i].bt, tbl[i].off,
                  tbl[i].breg, tbl[i].fl, tbl[i].fwe);
            tick();
            chk($sformatf("vec%0d.pc", i),      bus.pc, tbl[i].e_pc);
            chk($sformatf("vec%0d.taken", i),   {31'd0, bus.taken},   {31'd0, tbl[i].e_tk});
            chk($sformatf("vec%0d.flush", i),   {31'd0, bus.flush},   {31'd0, tbl[i].e_tk});
            chk($sformatf("vec%0d.link_we", i), {31'd0, bus.link_we}, {31'd0, tbl[i].e_lwe});
            chk($sformatf("vec%0d.link", i),    bus.link_addr, tbl[i].e_link);
            chk($sformatf("vec%0d.halted", i),  {31'd0, bus.halted},  {31'd0, tbl[i].e_halt});
            chk($sformatf("vec%0d.flags", i),   {27'd0, bus.flags_q}, {27'd0, m_flags});
        end

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128,
                  $urandom, 5'($urandom), $urandom_range(0, 1) == 1);
            tick();
            chk_model($sformatf("rnd%0d", n));
        end

        // Asynchronous reset landing while a taken bl's pulses are high.
        drive(0, 0, 1, 4'd0, 32'h0, 32'h0, 5'h0, 0);
        tick();
        drive(1, 0, 0, 4'd0, 32'h0, 32'h0, 5'b11111, 1);
        tick();
        drive(1, 0, 0, 4'd6, 32'h20, 32'h0, 5'h0, 0);
        tick();
        chk_model("prebl");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.pc",      bus.pc, 32'h0);
        chk("areset.link_we", {31'd0, bus.link_we}, 32'h0);
        chk("areset.taken",   {31'd0, bus.taken},   32'h0);
        chk("areset.flush",   {31'd0, bus.flush},   32'h0);
        chk("areset.flags",   {27'd0, bus.flags_q}, 32'h0);
        chk("areset.link",    bus.link_addr, 32'h0);
        model_reset();
        drive(1, 0, 0, 4'd0, 32'h0, 32'h0, 5'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_model("post_reset");
        chk("post_reset.first_step", bus.pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and branch-resolution stage sitting directly downstream of the ALU in the KGP-RISC datapath. It consumes the ALU flag vector and the register operand that the ALU passes through for branches, holds the carry state produced by `add`, and resolves every branch class. It updates the PC, produces the link address for `bl`, and pulses flush/taken for the fetch stage. A two-state run/halt controller gates PC advance.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- step  in  1  current instruction retires this cycle; PC may advance
- halt_req  in  1  request to stop advancing
- resume  in  1  leave HALT
- br_type  in  4  0 none, 1 b, 2 br (register), 3 bltz, 4 bz, 5 bnz, 6 bl, 7 bcy, 8 bncy; 9–15 treated as none
- br_offset  in  32  sign-extended byte offset, relative to current pc
- br_reg  in  32  register target for br (ALU pass-through of in1)
- alu_flags  in  5  [0] neg, [1] zero, [2] nonzero, [3] no-carry, [4] carry
- flags_we  in  1  capture alu_flags into flags_q (asserted on add/addi)
- pc  out  32  current PC
- link_addr  out  32  return address latched by bl
- link_we  out  1  one-cycle pulse: write link_addr to ra
- taken  out  1  one-cycle pulse: last retired branch was taken
- flush  out  1  one-cycle pulse: discard fetched instruction
- flags_q  out  5  stored flags
- halted  out  1  high in HALT

## Operation
- States: RUN, HALT. Reset enters RUN.
- RUN, step=0: no state change except the halt_req rule below.
- RUN, step=1:
  - Condition: b, bl, br always true; bltz uses alu_flags[0]; bz uses alu_flags[1]; bnz uses alu_flags[2]; bcy uses flags_q[4]; bncy uses flags_q[3].
  - Target: br uses br_reg; all others use pc + br_offset (32-bit, modulo 2^32). The target's bits [1:0] are forced to 0.
  - pc <= taken ? target : pc + PC_STEP. This wraps modulo 2^32, so 32'hFFFF_FFFC -> 0.
  - bl: link_addr <= pc + PC_STEP and link_we pulses, regardless of target.
  - taken and flush pulse when the condition is true.
  - flags_we=1: flags_q <= alu_flags. A bcy/bncy evaluated in the same cycle uses the old flags_q.
- flags_we with step=0 is ignored.
- halt_req in RUN:
  - With step=1, the instruction completes normally (pc, link, pulses), then the next state is HALT.
  - With step=0, the next state is HALT and pc is unchanged.
- HALT: step, br_type, and flags_we are ignored. halt_req is ignored. resume=1 -> RUN next cycle. No pulses are issued.
- Reset (asynchronous, any state, mid-branch included), all outputs immediately:
  - pc=RESET_PC
  - link_addr=0, flags_q=0
  - link_we=0, taken=0, flush=0
  - halted=0, state RUN

## Timing
- All outputs are registered; no combinational input-to-output path.
- Inputs are sampled on a rising edge; results are visible after that edge (latency 1).
- taken, flush, and link_we are high for exactly one cycle after the retiring edge. They deassert the following cycle unless another qualifying step occurs.
- Back-to-back taken branches on consecutive cycles produce continuous flush/taken highs, each cycle reflecting its own instruction.
- halted rises one cycle after the halt_req edge and falls one cycle after the resume edge.
- A reset release is synchronous to the design only through the flops. The first step is honoured on the first rising edge with rst_n=1.

## Test plan
- Reset then sequential run: rst_n low, release. Assert step with br_type=0 for 3 cycles -> pc 0, 4, 8, 12. Pulses stay 0.
- Conditional branches from pc=32'h100, br_offset=32'hFFFF_FFF0:
  - bz with alu_flags=5'b00010 -> pc=32'hF0, taken=1, flush=1.
  - bnz with the same flags -> pc=32'h104, taken=0.
- Carry path:
  - Step add with flags_we=1 and alu_flags=5'b10100, then bcy with offset 8 at pc=32'h200 -> pc=32'h208.
  - Step add with flags_we=1 and alu_flags=5'b01100, with bcy in the same cycle -> the old flags_q decides.
- bl at pc=32'h40 with offset 32'h20 -> pc=32'h60, link_addr=32'h44, link_we one-cycle pulse. br with br_reg=32'h47 -> pc=32'h44.
- Halt/resume:
  - halt_req with step on b -> branch completes, halted=1.
  - While halted, step and bz are ignored and pc is constant.
  - resume -> halted=0 next cycle.
  - Wrap check: pc=32'hFFFF_FFFC with step, no branch -> pc=0.
- Async reset mid-branch: assert rst_n low between edges while a taken bl is pending. pc=RESET_PC, link_we, taken, and flush are 0 immediately, and flags_q=0.
